snitch_icache_refill_coalescer: RTL and testbench
=================================================

// Module: snitch_icache_refill_coalescer
// PURPOSE
// - Sits directly downstream of the per-port L0 caches (after their request arbiter), in front of the L1 lookup/refill path.
// - Tracks in-flight line refills in a small pending table; merges a request for an already-pending line into that entry by OR-ing its ID bit.
// - Issues one downstream request per unique line; on response, returns data once with the merged ID mask so all requesting L0s latch it.
// PARAMETERS
// - CFG            config_t '0  shared icache config; uses FETCH_AW, LINE_WIDTH, LINE_ALIGN, ID_WIDTH
// - PENDING_COUNT  int      4   pending-table entries (power of two, >=2); tag width PW = $clog2(PENDING_COUNT)
// PORTS
// - clk_i             in   1           clock, all state on rising edge
// - rst_i             in   1           asynchronous reset, active-high
// - in_req_addr_i     in   FETCH_AW    line address from L0 (low LINE_ALIGN bits ignored)
// - in_req_id_i       in   ID_WIDTH    one-hot requester ID (L0 port x prefetch bit)
// - in_req_valid_i    in   1           request valid
// - in_req_ready_o    out  1           request accepted (combinational)
// - out_req_addr_o    out  FETCH_AW    line-aligned address to L1
// - out_req_tag_o     out  PW          pending-entry index
// - out_req_valid_o   out  1           downstream request valid (registered)
// - out_req_ready_i   in   1           downstream ready
// - out_rsp_data_i    in   LINE_WIDTH  refill line
// - out_rsp_error_i   in   1           refill error
// - out_rsp_tag_i     in   PW          entry index being answered
// - out_rsp_valid_i   in   1           response valid
// - out_rsp_ready_o   out  1           = in_rsp_ready_i
// - in_rsp_data_o     out  LINE_WIDTH  passthrough of out_rsp_data_i
// - in_rsp_error_o    out  1           passthrough of out_rsp_error_i
// - in_rsp_id_o       out  ID_WIDTH    merged ID mask of entry out_rsp_tag_i
// - in_rsp_valid_o    out  1           = out_rsp_valid_i
// - in_rsp_ready_i    in   1           upstream ready
// BEHAVIOUR
// - Entry = {vld, line = addr>>LINE_ALIGN, idmask}. Reset: all entries invalid/zero, issue register empty, out_req_valid_o=0.
// - Outputs to in_rsp_*/out_rsp_ready_o are pure combinational passthrough; zero latency.
// - Hit: in_req_valid_i and a vld entry's line matches, and that entry is not retiring this cycle.
//   -> in_req_ready_o=1, entry idmask |= in_req_id_i next edge; no downstream request.
// - Miss: no hit, a free entry exists, issue register empty (or draining this cycle).
//   -> in_req_ready_o=1; lowest free index allocated (vld=1, line, idmask=in_req_id_i).
//   -> issue register loaded; out_req_valid_o=1 from next cycle with addr=line<<LINE_ALIGN, tag=index.
//   -> Held stable until out_req_ready_i.
// - Stall (in_req_ready_o=0):
//   - miss with table full;
//   - miss with issue register occupied and not draining;
//   - request matching an entry retiring this cycle. The next cycle it is re-evaluated as a miss.
//   - Hits are accepted while the issue register stalls.
// - Retire: out_rsp_valid_i & in_rsp_ready_i frees entry out_rsp_tag_i at the edge; index reusable next cycle.
//   - in_rsp_id_o reflects idmask as of this cycle (a same-cycle merge is excluded by the stall rule).
// - Simultaneous allocate + retire of different entries: both take effect. Allocation never picks the retiring index in the same cycle.
// - Response for an invalid entry: illegal, asserted; output ID mask '0.
// - Error responses are retired exactly like data responses; error is not cached.
// - Multiple matching entries: impossible by construction; asserted onehot0.
// - Reset mid-operation: table and issue register cleared immediately. Later responses are illegal (L1 is reset together).
// STRUCTURE
// - snitch_icache_pkg: add typedef pending_entry_t (line, idmask, vld) parameterised via CFG widths.
// - Free-entry selection: common_cells lzc, no new sub-module. Single module, FF macros with active-high async reset.
// - Assertions: request stable while !ready (both sides); match onehot0; rsp tag points to vld entry.
// TESTING
// - Single miss 0x1000, id 0b0001 -> out_req addr 0x1000 tag 0 one cycle later; rsp -> in_rsp_id 0b0001, entry 0 free.
// - Miss 0x1000 id 0b0001, then 0x1010 (same line) id 0b0100 -> one downstream req; rsp id 0b0101.
// - PENDING_COUNT=4, four distinct lines outstanding, fifth miss -> in_req_ready_o=0 until a rsp retires; then allocated to freed index.
// - out_req_ready_i low 5 cycles -> addr/tag stable; hit to pending line accepted meanwhile; new miss stalled.
// - Request to line retiring same cycle -> stalled 1 cycle, then fresh entry + new downstream req.
// - Assert rst_i mid-traffic with 3 entries pending -> all outputs 0, next miss allocates tag 0.

Source files
------------

// File: rtl/snitch_icache_refill_coalescer_pkg.sv
// Shared icache configuration types and helpers for the refill coalescer.
package snitch_icache_refill_coalescer_pkg;

   typedef struct packed {
      int unsigned FETCH_AW;
      int unsigned LINE_WIDTH;
      int unsigned LINE_ALIGN;
      int unsigned ID_WIDTH;
   } config_t;

   localparam config_t DefaultCfg = '{
      FETCH_AW:   32,
      LINE_WIDTH: 256,
      LINE_ALIGN: 5,
      ID_WIDTH:   4
   };

   // Number of address bits that identify a cache line.
   function automatic int unsigned line_width(config_t cfg);
      return cfg.FETCH_AW - cfg.LINE_ALIGN;
   endfunction

endpackage

// File: rtl/snitch_icache_refill_coalescer.sv
// Pending-refill table: merges requests to in-flight lines and issues one
// downstream refill per unique line; responses fan out via the merged ID mask.
module snitch_icache_refill_coalescer
   import snitch_icache_refill_coalescer_pkg::*;
#(
   parameter config_t     CFG           = DefaultCfg,
   parameter int unsigned PENDING_COUNT = 4,
   localparam int unsigned PW           = $clog2(PENDING_COUNT)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [CFG.FETCH_AW-1:0]   in_req_addr_i,
   input  logic [CFG.ID_WIDTH-1:0]   in_req_id_i,
   input  logic                      in_req_valid_i,
   output logic                      in_req_ready_o,
   output logic [CFG.FETCH_AW-1:0]   out_req_addr_o,
   output logic [PW-1:0]             out_req_tag_o,
   output logic                      out_req_valid_o,
   input  logic                      out_req_ready_i,
   input  logic [CFG.LINE_WIDTH-1:0] out_rsp_data_i,
   input  logic                      out_rsp_error_i,
   input  logic [PW-1:0]             out_rsp_tag_i,
   input  logic                      out_rsp_valid_i,
   output logic                      out_rsp_ready_o,
   output logic [CFG.LINE_WIDTH-1:0] in_rsp_data_o,
   output logic                      in_rsp_error_o,
   output logic [CFG.ID_WIDTH-1:0]   in_rsp_id_o,
   output logic                      in_rsp_valid_o,
   input  logic                      in_rsp_ready_i
);

   localparam int unsigned AW = CFG.FETCH_AW;
   localparam int unsigned LA = CFG.LINE_ALIGN;
   localparam int unsigned IW = CFG.ID_WIDTH;
   localparam int unsigned LW = line_width(CFG);

   typedef struct packed {
      logic [LW-1:0] line;
      logic [IW-1:0] idmask;
      logic          vld;
   } pending_entry_t;

   pending_entry_t r_tbl      [PENDING_COUNT];
   pending_entry_t w_tbl_next [PENDING_COUNT];

   logic          r_issue_vld;
   logic [LW-1:0] r_issue_line;
   logic [PW-1:0] r_issue_tag;

   logic [LW-1:0]            w_req_line;
   logic [PENDING_COUNT-1:0] w_match;
   logic [PENDING_COUNT-1:0] w_free;
   logic [PENDING_COUNT-1:0] w_retire_oh;
   logic [PW-1:0]            w_alloc_idx;
   logic                     w_retire;
   logic                     w_match_retiring;
   logic                     w_issue_free;
   logic                     w_hit;
   logic                     w_alloc;
   logic                     w_unused_offset;

   assign w_req_line      = in_req_addr_i[AW-1:LA];
   assign w_unused_offset = ^in_req_addr_i[LA-1:0];
   assign w_retire        = out_rsp_valid_i & in_rsp_ready_i;

   always_comb begin
      w_match     = '0;
      w_free      = '0;
      w_retire_oh = '0;
      w_alloc_idx = '0;
      for (int i = 0; i < int'(PENDING_COUNT); i++) begin
         w_match[i]     = r_tbl[i].vld && (r_tbl[i].line == w_req_line);
         w_free[i]      = !r_tbl[i].vld;
         w_retire_oh[i] = w_retire && (out_rsp_tag_i == PW'(i));
      end
      // Lowest free index wins; a retiring entry is still valid so it is never picked.
      for (int i = int'(PENDING_COUNT) - 1; i >= 0; i--) begin
         if (w_free[i]) w_alloc_idx = PW'(i);
      end
   end

   assign w_match_retiring = |(w_match & w_retire_oh);
   assign w_issue_free     = !r_issue_vld || out_req_ready_i;
   assign w_hit            = in_req_valid_i && (|w_match) && !w_match_retiring;
   assign w_alloc          = in_req_valid_i && !(|w_match) && (|w_free) && w_issue_free;
   assign in_req_ready_o   = w_hit | w_alloc;

   always_comb begin
      for (int i = 0; i < int'(PENDING_COUNT); i++) begin
         w_tbl_next[i] = r_tbl[i];
         if (w_retire_oh[i]) w_tbl_next[i] = '0;
         if (w_hit && w_match[i]) w_tbl_next[i].idmask = r_tbl[i].idmask | in_req_id_i;
         if (w_alloc && (w_alloc_idx == PW'(i))) begin
            w_tbl_next[i] = '{line: w_req_line, idmask: in_req_id_i, vld: 1'b1};
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < int'(PENDING_COUNT); i++) r_tbl[i] <= '0;
         r_issue_vld  <= 1'b0;
         r_issue_line <= '0;
         r_issue_tag  <= '0;
      end else begin
         r_tbl <= w_tbl_next;
         if (w_alloc) begin
            r_issue_vld  <= 1'b1;
            r_issue_line <= w_req_line;
            r_issue_tag  <= w_alloc_idx;
         end else if (out_req_ready_i) begin
            r_issue_vld  <= 1'b0;
            r_issue_line <= '0;
            r_issue_tag  <= '0;
         end
      end
   end

   assign out_req_valid_o = r_issue_vld;
   assign out_req_addr_o  = {r_issue_line, {LA{1'b0}}};
   assign out_req_tag_o   = r_issue_tag;

   assign out_rsp_ready_o = in_rsp_ready_i;
   assign in_rsp_data_o   = out_rsp_data_i;
   assign in_rsp_error_o  = out_rsp_error_i;
   assign in_rsp_valid_o  = out_rsp_valid_i;
   // Invalid entries read as zero so a stray response wakes no requester.
   assign in_rsp_id_o     = r_tbl[out_rsp_tag_i].vld ? r_tbl[out_rsp_tag_i].idmask : '0;

   a_in_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      in_req_valid_i && !in_req_ready_o |=>
         in_req_valid_i && $stable(in_req_addr_i) && $stable(in_req_id_i));

   a_out_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      out_req_valid_o && !out_req_ready_i |=>
         out_req_valid_o && $stable(out_req_addr_o) && $stable(out_req_tag_o));

   a_match_onehot0: assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(w_match));

   a_rsp_tag_vld: assert property (@(posedge clk_i) disable iff (rst_i)
      out_rsp_valid_i |-> r_tbl[out_rsp_tag_i].vld);

endmodule

// File: tb/tb_snitch_icache_refill_coalescer.sv
// Bench for the refill coalescer: scripted vector table, corner sequences and
// a randomized run against a line-keyed pending-set model.
module tb_snitch_icache_refill_coalescer;

   logic         clk = 1'b0;
   logic         rst_i;
   logic [31:0]  in_req_addr;
   logic [3:0]   in_req_id;
   logic         in_req_valid;
   logic         in_req_ready;
   logic [31:0]  out_req_addr;
   logic [1:0]   out_req_tag;
   logic         out_req_valid;
   logic         out_req_ready;
   logic [255:0] out_rsp_data;
   logic         out_rsp_error;
   logic [1:0]   out_rsp_tag;
   logic         out_rsp_valid;
   logic         out_rsp_ready;
   logic [255:0] in_rsp_data;
   logic         in_rsp_error;
   logic [3:0]   in_rsp_id;
   logic         in_rsp_valid;
   logic         in_rsp_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   snitch_icache_refill_coalescer dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .in_req_addr_i   (in_req_addr),
      .in_req_id_i     (in_req_id),
      .in_req_valid_i  (in_req_valid),
      .in_req_ready_o  (in_req_ready),
      .out_req_addr_o  (out_req_addr),
      .out_req_tag_o   (out_req_tag),
      .out_req_valid_o (out_req_valid),
      .out_req_ready_i (out_req_ready),
      .out_rsp_data_i  (out_rsp_data),
      .out_rsp_error_i (out_rsp_error),
      .out_rsp_tag_i   (out_rsp_tag),
      .out_rsp_valid_i (out_rsp_valid),
      .out_rsp_ready_o (out_rsp_ready),
      .in_rsp_data_o   (in_rsp_data),
      .in_rsp_error_o  (in_rsp_error),
      .in_rsp_id_o     (in_rsp_id),
      .in_rsp_valid_o  (in_rsp_valid),
      .in_rsp_ready_i  (in_rsp_ready)
   );

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_req_valid  = 1'b0;
      in_req_addr   = '0;
      in_req_id     = '0;
      out_req_ready = 1'b1;
      out_rsp_valid = 1'b0;
      out_rsp_tag   = '0;
      out_rsp_error = 1'b0;
      out_rsp_data  = '0;
      in_rsp_ready  = 1'b1;
   endtask

   typedef struct {
      logic        req_v;
      logic [31:0] addr;
      logic [3:0]  id;
      logic        ordy;
      logic        rsp_v;
      logic [1:0]  rsp_tag;
      logic        exp_rdy;
      logic        exp_ov;
      logic [31:0] exp_addr;
      logic [1:0]  exp_tag;
      logic [3:0]  exp_id;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(logic req_v, logic [31:0] addr, logic [3:0] id, logic ordy,
                              logic rsp_v, logic [1:0] rsp_tag, logic exp_rdy, logic exp_ov,
                              logic [31:0] exp_addr, logic [1:0] exp_tag, logic [3:0] exp_id);
      vec_t r;
      r = '{req_v, addr, id, ordy, rsp_v, rsp_tag, exp_rdy, exp_ov, exp_addr, exp_tag, exp_id};
      return r;
   endfunction

   // Reference model: pending lines keyed by tag, FIFO of unissued tags, tags held by L1.
   logic [26:0] m_line [int];
   logic [3:0]  m_mask [int];
   int          q_iss [$];
   int          l1 [$];

   function automatic int find_tag(logic [26:0] line);
      foreach (m_line[t]) if (m_line[t] == line) return t;
      return -1;
   endfunction

   function automatic int lowest_free();
      for (int k = 0; k < 4; k++) if (!m_line.exists(k)) return k;
      return -1;
   endfunction

   int          t_hit, t_new, sel;
   logic        retire, exp_rdy, acc, req_hold;
   logic [26:0] line;

   initial begin
      idle();
      rst_i = 1'b1;
      cyc();
      cyc();
      rst_i = 1'b0;
      #1;
      chk("reset_out_req_valid", out_req_valid, 0);
      chk("reset_out_req_addr", out_req_addr, 0);
      cyc();

      // Single miss; same-line merge; table full; issue stall with hit and stalled miss.
      vecs.push_back(v(1, 'h1000, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 'h1000, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(v(1, 'h1000, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 'h1010, 4, 0, 0, 0, 1, 1, 'h1000, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 'h1000, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5));
      vecs.push_back(v(1, 'h2000, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 'h3000, 2, 1, 0, 0, 1, 1, 'h2000, 0, 0));
      vecs.push_back(v(1, 'h4000, 4, 1, 0, 0, 1, 1, 'h3000, 1, 0));
      vecs.push_back(v(1, 'h5000, 8, 1, 0, 0, 1, 1, 'h4000, 2, 0));
      vecs.push_back(v(1, 'h6000, 1, 1, 0, 0, 0, 1, 'h5000, 3, 0));
      vecs.push_back(v(1, 'h6000, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(v(1, 'h6000, 1, 1, 1, 2, 0, 0, 0, 0, 4));
      vecs.push_back(v(1, 'h6000, 1, 1, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 'h6000, 2, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(v(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2));
      vecs.push_back(v(0, 0, 0, 1, 1, 3, 0, 0, 0, 0, 8));
      vecs.push_back(v(0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 1));
      vecs.push_back(v(1, 'h7000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
      vecs.push_back(v(1, 'h7008, 2, 0, 0, 0, 1, 1, 'h7000, 0, 0));
      for (int i = 0; i < 4; i++) vecs.push_back(v(1, 'h8000, 1, 0, 0, 0, 0, 1, 'h7000, 0, 0));
      vecs.push_back(v(1, 'h8000, 1, 1, 0, 0, 1, 1, 'h7000, 0, 0));
      vecs.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 'h8000, 1, 0));
      vecs.push_back(v(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 3));
      vecs.push_back(v(0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 1));

      foreach (vecs[i]) begin
         in_req_valid  = vecs[i].req_v;
         in_req_addr   = vecs[i].addr;
         in_req_id     = vecs[i].id;
         out_req_ready = vecs[i].ordy;
         out_rsp_valid = vecs[i].rsp_v;
         out_rsp_tag   = vecs[i].rsp_tag;
         out_rsp_error = vecs[i].rsp_v & vecs[i].rsp_tag[0];
         out_rsp_data  = {8{$urandom}};
         in_rsp_ready  = 1'b1;
         #1;
         if (vecs[i].req_v) chk($sformatf("vec%0d_req_ready", i), in_req_ready, vecs[i].exp_rdy);
         chk($sformatf("vec%0d_out_valid", i), out_req_valid, vecs[i].exp_ov);
         if (vecs[i].exp_ov) begin
            chk($sformatf("vec%0d_out_addr", i), out_req_addr, vecs[i].exp_addr);
            chk($sformatf("vec%0d_out_tag", i), out_req_tag, vecs[i].exp_tag);
         end
         if (vecs[i].rsp_v) begin
            chk($sformatf("vec%0d_rsp_id", i), in_rsp_id, vecs[i].exp_id);
            chk($sformatf("vec%0d_rsp_data", i), in_rsp_data, out_rsp_data);
            chk($sformatf("vec%0d_rsp_err", i), in_rsp_error, vecs[i].rsp_tag[0]);
         end
         cyc();
      end
      idle();

      // Request to a line that retires in the same cycle.
      in_req_valid = 1; in_req_addr = 'h9000; in_req_id = 1; #1;
      chk("rc_alloc_ready", in_req_ready, 1);
      cyc(); idle(); #1;
      chk("rc_issue_valid", out_req_valid, 1);
      chk("rc_issue_addr", out_req_addr, 'h9000);
      cyc();
      in_req_valid = 1; in_req_addr = 'h9000; in_req_id = 2;
      out_rsp_valid = 1; out_rsp_tag = 0; #1;
      chk("rc_retire_stall", in_req_ready, 0);
      chk("rc_retire_id", in_rsp_id, 1);
      cyc(); out_rsp_valid = 0; #1;
      chk("rc_realloc_ready", in_req_ready, 1);
      cyc(); idle(); #1;
      chk("rc_reissue_valid", out_req_valid, 1);
      chk("rc_reissue_addr", out_req_addr, 'h9000);
      chk("rc_reissue_tag", out_req_tag, 0);
      cyc(); out_rsp_valid = 1; out_rsp_tag = 0; #1;
      chk("rc_fresh_id", in_rsp_id, 2);
      cyc(); idle();

      // Reset mid-traffic with three entries pending.
      for (int i = 0; i < 3; i++) begin
         in_req_valid = 1; in_req_addr = 32'('hA000 + i * 'h1000); in_req_id = 4'(1 << i); #1;
         chk($sformatf("rst_alloc%0d", i), in_req_ready, 1);
         cyc();
      end
      idle(); out_req_ready = 0; #1;
      chk("rst_pre_valid", out_req_valid, 1);
      chk("rst_pre_tag", out_req_tag, 2);
      #2 rst_i = 1; #1;
      chk("rst_out_valid", out_req_valid, 0);
      chk("rst_out_addr", out_req_addr, 0);
      chk("rst_out_tag", out_req_tag, 0);
      cyc(); rst_i = 0; out_req_ready = 1;
      in_req_valid = 1; in_req_addr = 'hD000; in_req_id = 8; #1;
      chk("rst_next_ready", in_req_ready, 1);
      cyc(); idle(); #1;
      chk("rst_next_tag", out_req_tag, 0);
      chk("rst_next_addr", out_req_addr, 'hD000);
      cyc(); out_rsp_valid = 1; out_rsp_tag = 0; #1;
      chk("rst_next_id", in_rsp_id, 8);
      cyc(); idle(); cyc();

      // Randomized traffic against the model, which starts empty.
      req_hold = 0;
      for (int c = 0; c < 1500; c++) begin
         if (!req_hold) begin
            if ($urandom % 10 < 6) begin
               sel          = int'($urandom % 6);
               in_req_valid = 1;
               in_req_addr  = 32'('h4000 + sel * 'h20 + int'($urandom % 32));
               in_req_id    = 4'(1 << ($urandom % 4));
            end else begin
               in_req_valid = 0;
            end
         end
         out_req_ready = ($urandom % 4) != 0;
         if (!out_rsp_valid && l1.size() > 0 && ($urandom % 2) == 1) begin
            sel           = int'($urandom % l1.size());
            out_rsp_valid = 1;
            out_rsp_tag   = 2'(l1[sel]);
            out_rsp_data  = {8{$urandom}};
            out_rsp_error = 1'($urandom % 2);
         end
         in_rsp_ready = ($urandom % 4) != 0;
         #1;

         retire = out_rsp_valid && in_rsp_ready;
         line   = in_req_addr[31:5];
         t_hit  = in_req_valid ? find_tag(line) : -1;
         if (t_hit >= 0) exp_rdy = !(retire && t_hit == int'(out_rsp_tag));
         else exp_rdy = (m_line.num() < 4) && (q_iss.size() == 0 || out_req_ready);
         acc = in_req_valid && exp_rdy;
         if (in_req_valid) chk($sformatf("rnd%0d_req_ready", c), in_req_ready, exp_rdy);
         chk($sformatf("rnd%0d_out_valid", c), out_req_valid, q_iss.size() != 0);
         if (q_iss.size() != 0) begin
            chk($sformatf("rnd%0d_out_addr", c), out_req_addr, {m_line[q_iss[0]], 5'b0});
            chk($sformatf("rnd%0d_out_tag", c), out_req_tag, q_iss[0]);
         end
         chk($sformatf("rnd%0d_rsp_ready", c), out_rsp_ready, in_rsp_ready);
         if (out_rsp_valid) begin
            chk($sformatf("rnd%0d_rsp_id", c), in_rsp_id, m_mask[int'(out_rsp_tag)]);
            chk($sformatf("rnd%0d_rsp_data", c), in_rsp_data, out_rsp_data);
            chk($sformatf("rnd%0d_rsp_err", c), in_rsp_error, out_rsp_error);
         end

         t_new = lowest_free();
         if (q_iss.size() != 0 && out_req_ready) l1.push_back(q_iss.pop_front());
         if (retire) begin
            m_line.delete(int'(out_rsp_tag));
            m_mask.delete(int'(out_rsp_tag));
            foreach (l1[k]) if (l1[k] == int'(out_rsp_tag)) begin l1.delete(k); break; end
         end
         if (acc && t_hit >= 0) m_mask[t_hit] = m_mask[t_hit] | in_req_id;
         else if (acc) begin
            m_line[t_new] = line;
            m_mask[t_new] = in_req_id;
            q_iss.push_back(t_new);
         end

         cyc();
         req_hold = in_req_valid && !acc;
         if (retire) out_rsp_valid = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
